// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: FSM state encoding and
// grant identifiers, also used by the cache controller.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_D = 2'd1,
      SERVE_I = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one main-memory block port between the i-cache
// and the d-cache, alternating on contention through a last-grant bit.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 28,
   parameter int BLOCK_W = 128
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_address,
   output logic [BLOCK_W-1:0] i_readdata,
   output logic               i_busywait,

   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_address,
   input  logic [BLOCK_W-1:0] d_writedata,
   output logic [BLOCK_W-1:0] d_readdata,
   output logic               d_busywait,

   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_ack
);

   arb_state_t state;
   arb_state_t state_nxt;
   grant_t     last_grant;
   logic       done_i;
   logic       done_d;
   logic       d_req;
   logic       d_elig;
   logic       i_elig;

   assign d_req      = d_read | d_write;
   assign i_busywait = i_read & ~done_i;
   assign d_busywait = d_req & ~done_d;

   // A requester in its done cycle still holds its request; mask it so the
   // finished transaction is not granted a second time.
   assign d_elig = d_req & ~done_d;
   assign i_elig = i_read & ~done_i;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_elig && (!i_elig || last_grant == GRANT_I)) begin
               state_nxt = SERVE_D;
            end else if (i_elig) begin
               state_nxt = SERVE_I;
            end
         end
         SERVE_D: if (mem_ack) state_nxt = IDLE;
         SERVE_I: if (mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         last_grant    <= GRANT_I;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         i_readdata    <= '0;
         d_readdata    <= '0;
         done_i        <= 1'b0;
         done_d        <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_i <= 1'b0;
         done_d <= 1'b0;
         case (state)
            IDLE: begin
               if (state_nxt == SERVE_D) begin
                  // A combined read+write request is a writeback.
                  mem_address   <= d_address;
                  mem_writedata <= d_writedata;
                  mem_write     <= d_write;
                  mem_read      <= ~d_write;
                  last_grant    <= GRANT_D;
               end else if (state_nxt == SERVE_I) begin
                  mem_address <= i_address;
                  mem_write   <= 1'b0;
                  mem_read    <= 1'b1;
                  last_grant  <= GRANT_I;
               end
            end
            SERVE_D: begin
               if (mem_ack) begin
                  if (mem_read) d_readdata <= mem_readdata;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  done_d    <= 1'b1;
               end
            end
            SERVE_I: begin
               if (mem_ack) begin
                  i_readdata <= mem_readdata;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  done_i     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// two-requester traffic against a transaction-level memory/cache model.
module tb_mem_arbiter;

   localparam int ADDR_W  = 28;
   localparam int BLOCK_W = 128;

   logic               clk;
   logic               reset;
   logic               i_read;
   logic [ADDR_W-1:0]  i_address;
   logic [BLOCK_W-1:0] i_readdata;
   logic               i_busywait;
   logic               d_read;
   logic               d_write;
   logic [ADDR_W-1:0]  d_address;
   logic [BLOCK_W-1:0] d_writedata;
   logic [BLOCK_W-1:0] d_readdata;
   logic               d_busywait;
   logic               mem_read;
   logic               mem_write;
   logic [ADDR_W-1:0]  mem_address;
   logic [BLOCK_W-1:0] mem_writedata;
   logic [BLOCK_W-1:0] mem_readdata;
   logic               mem_ack;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [BLOCK_W-1:0] exp_i_rd;
   logic [BLOCK_W-1:0] exp_d_rd;

   // Random-traffic shared state: outstanding requests, memory log, contents.
   logic               i_pend, d_pend, i_fin, d_fin;
   logic [ADDR_W-1:0]  i_exp_addr, d_exp_addr, last_ack_addr;
   logic               d_exp_wr;
   logic [BLOCK_W-1:0] d_exp_wdata;
   int                 last_ack_cyc, i_starts, d_starts;
   logic [BLOCK_W-1:0] mem_q    [logic [ADDR_W-1:0]];
   logic [BLOCK_W-1:0] d_shadow [logic [ADDR_W-1:0]];

   mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ack(mem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   function automatic logic [BLOCK_W-1:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [BLOCK_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
      return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_i_rd = '0;
      exp_d_rd = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: read=%b write=%b want 0 0", mem_read, mem_write);
      end
      checks++;
      if (mem_address !== '0 || mem_writedata !== '0) begin
         errors++;
         $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", mem_address, mem_writedata);
      end
      checks++;
      if (i_readdata !== '0 || d_readdata !== '0) begin
         errors++;
         $display("FAIL reset_readdata: i=%h d=%h want 0", i_readdata, d_readdata);
      end
      checks++;
      if (i_busywait !== 1'b0 || d_busywait !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: i=%b d=%b want 0 0", i_busywait, d_busywait);
      end
      reset = 1'b1;
      exp_i_rd = '0;
      exp_d_rd = '0;
   endtask

   task automatic test_single_iread();
      logic [ADDR_W-1:0]  addr;
      logic [BLOCK_W-1:0] blk;
      addr = 28'h0000010;
      blk  = rand_blk();
      @(negedge clk);
      i_address = addr;
      i_read    = 1'b1;
      #1;
      checks++;
      if (i_busywait !== 1'b1 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL single_rise: busy=%b mem_read=%b want 1 0", i_busywait, mem_read);
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== addr || i_busywait !== 1'b1) begin
            errors++;
            $display("FAIL single_strobe c%0d: read=%b write=%b addr=%h busy=%b want 1 0 %h 1",
                     c, mem_read, mem_write, mem_address, i_busywait, addr);
         end
         if (c == 3) begin
            mem_readdata = blk;
            mem_ack      = 1'b1;
         end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (mem_read !== 1'b0 || i_busywait !== 1'b0 || i_readdata !== blk) begin
         errors++;
         $display("FAIL single_done: read=%b busy=%b data=%h want 0 0 %h", mem_read, i_busywait, i_readdata, blk);
      end
      exp_i_rd = blk;
      i_read = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b0 || i_busywait !== 1'b0 || i_readdata !== blk) begin
         errors++;
         $display("FAIL single_after: read=%b busy=%b data=%h want 0 0 %h", mem_read, i_busywait, i_readdata, blk);
      end
   endtask

   // Rounds: both together after reset (D first), d alone, both together
   // after a D grant (I first).
   task automatic test_simultaneous();
      int  n_txn [3]    = '{2, 1, 2};
      bit  first_d [3]  = '{1'b1, 1'b1, 1'b0};
      logic [ADDR_W-1:0]  ia, da, ea;
      logic [BLOCK_W-1:0] blk;
      bit   own_d;
      int   lat;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         ia = 28'($urandom_range(0, 28'h7FFFFFF));
         da = 28'h8000000 | 28'($urandom_range(0, 28'h7FFFFFF));
         i_address = ia; d_address = da;
         d_read = 1'b1;
         i_read = (n_txn[r] == 2);
         for (int t = 0; t < n_txn[r]; t++) begin
            own_d = (t == 0) ? first_d[r] : !first_d[r];
            ea    = own_d ? da : ia;
            lat   = $urandom_range(1, 3);
            blk   = rand_blk();
            for (int c = 1; c <= lat; c++) begin
               @(negedge clk);
               checks++;
               if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== ea) begin
                  errors++;
                  $display("FAIL simul_strobe r%0d t%0d c%0d: read=%b write=%b addr=%h want 1 0 %h",
                           r, t, c, mem_read, mem_write, mem_address, ea);
               end
               if (c == lat) begin
                  mem_readdata = blk;
                  mem_ack      = 1'b1;
               end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            checks++;
            if (own_d) begin
               exp_d_rd = blk;
               if (d_busywait !== 1'b0 || d_readdata !== blk || mem_read !== 1'b0 ||
                   (t == 0 && n_txn[r] == 2 && i_busywait !== 1'b1)) begin
                  errors++;
                  $display("FAIL simul_done_d r%0d t%0d: dbusy=%b ibusy=%b data=%h read=%b want data %h",
                           r, t, d_busywait, i_busywait, d_readdata, mem_read, blk);
               end
               d_read = 1'b0;
            end else begin
               exp_i_rd = blk;
               if (i_busywait !== 1'b0 || i_readdata !== blk || mem_read !== 1'b0 ||
                   (t == 0 && d_busywait !== 1'b1)) begin
                  errors++;
                  $display("FAIL simul_done_i r%0d t%0d: ibusy=%b dbusy=%b data=%h read=%b want data %h",
                           r, t, i_busywait, d_busywait, i_readdata, mem_read, blk);
               end
               i_read = 1'b0;
            end
         end
      end
   endtask

   task automatic test_alternation();
      logic [ADDR_W-1:0]  ia, da, ea;
      logic [BLOCK_W-1:0] blk;
      bit   own_d, at_strobe;
      int   lat;
      @(negedge clk);
      da = 28'h8000000 | 28'($urandom_range(0, 28'h7FFFFFF));
      d_address = da; d_read = 1'b1;
      @(negedge clk);
      ia = 28'($urandom_range(0, 28'h7FFFFFF));
      i_address = ia; i_read = 1'b1;
      at_strobe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         own_d = (k % 2 == 0);
         ea    = own_d ? da : ia;
         lat   = $urandom_range(1, 3);
         blk   = rand_blk();
         for (int c = 1; c <= lat; c++) begin
            if (!(c == 1 && at_strobe)) @(negedge clk);
            checks++;
            if (mem_read !== 1'b1 || mem_address !== ea) begin
               errors++;
               $display("FAIL alt_order k%0d c%0d: read=%b addr=%h want 1 %h", k, c, mem_read, mem_address, ea);
            end
            if (c == lat) begin
               mem_readdata = blk;
               mem_ack      = 1'b1;
            end
         end
         @(negedge clk);
         mem_ack = 1'b0;
         checks++;
         if (own_d ? (d_busywait !== 1'b0 || d_readdata !== blk)
                   : (i_busywait !== 1'b0 || i_readdata !== blk)) begin
            errors++;
            $display("FAIL alt_done k%0d: ibusy=%b dbusy=%b idata=%h ddata=%h want %h",
                     k, i_busywait, d_busywait, i_readdata, d_readdata, blk);
         end
         if (own_d) begin
            exp_d_rd = blk;
            d_read   = 1'b0;
         end else begin
            exp_i_rd = blk;
            i_read   = 1'b0;
         end
         at_strobe = 1'b0;
         if (k < 2) begin
            @(negedge clk);
            if (own_d) begin
               da = 28'h8000000 | 28'($urandom_range(0, 28'h7FFFFFF));
               d_address = da; d_read = 1'b1;
            end else begin
               ia = 28'($urandom_range(0, 28'h7FFFFFF));
               i_address = ia; i_read = 1'b1;
            end
            at_strobe = 1'b1;
         end
      end
   endtask

   task automatic test_write();
      logic [ADDR_W-1:0]  addr;
      logic [BLOCK_W-1:0] wd;
      int lat;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         addr = (n == 0) ? 28'h00000AB : 28'($urandom_range(0, 28'hFFFFFFF));
         wd   = (n == 0) ? 128'hDEAD0123456789ABCDEF00112233BEEF : rand_blk();
         lat  = $urandom_range(1, 4);
         d_address = addr; d_writedata = wd;
         d_write = 1'b1;
         d_read  = (n == 0);
         for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== addr || mem_writedata !== wd) begin
               errors++;
               $display("FAIL write_strobe n%0d c%0d: write=%b read=%b addr=%h wdata=%h want 1 0 %h %h",
                        n, c, mem_write, mem_read, mem_address, mem_writedata, addr, wd);
            end
            if (c == lat) begin
               mem_readdata = rand_blk();
               mem_ack      = 1'b1;
            end
         end
         @(negedge clk);
         mem_ack = 1'b0;
         checks++;
         if (d_busywait !== 1'b0 || d_readdata !== exp_d_rd || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL write_done n%0d: busy=%b ddata=%h write=%b want 0 %h 0",
                     n, d_busywait, d_readdata, mem_write, exp_d_rd);
         end
         d_read = 1'b0; d_write = 1'b0;
      end
   endtask

   task automatic test_reset_mid_service();
      logic [ADDR_W-1:0]  da;
      logic [BLOCK_W-1:0] blk;
      @(negedge clk);
      i_address = 28'($urandom_range(0, 28'hFFFFFFF));
      i_read    = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: read=%b want 1", mem_read);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_readdata !== '0 || d_readdata !== '0) begin
         errors++;
         $display("FAIL rstmid_drop: read=%b write=%b idata=%h ddata=%h want 0 0 0 0",
                  mem_read, mem_write, i_readdata, d_readdata);
      end
      reset = 1'b1; i_read = 1'b0;
      exp_i_rd = '0; exp_d_rd = '0;
      @(negedge clk);
      mem_readdata = rand_blk();
      mem_ack      = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (i_readdata !== '0 || d_readdata !== '0 || mem_read !== 1'b0 || i_busywait !== 1'b0 || d_busywait !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_stray: idata=%h ddata=%h read=%b ibusy=%b dbusy=%b want all 0",
                  i_readdata, d_readdata, mem_read, i_busywait, d_busywait);
      end
      da  = 28'($urandom_range(0, 28'hFFFFFFF));
      blk = rand_blk();
      d_address = da; d_read = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== da) begin
         errors++;
         $display("FAIL rstmid_next: read=%b addr=%h want 1 %h", mem_read, mem_address, da);
      end
      mem_readdata = blk; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (d_busywait !== 1'b0 || d_readdata !== blk) begin
         errors++;
         $display("FAIL rstmid_next_done: busy=%b data=%h want 0 %h", d_busywait, d_readdata, blk);
      end
      exp_d_rd = blk;
      d_read = 1'b0;
   endtask

   // Memory model: random latency, stores writes, checks each transaction
   // against the requester that owns it and that strobes stay stable.
   task automatic responder();
      bit busy, post_ack;
      int cnt, lat;
      logic [ADDR_W-1:0]  t_addr;
      logic [BLOCK_W-1:0] t_wd;
      logic t_rd, t_wr;
      busy = 1'b0; post_ack = 1'b0; cnt = 0; lat = 1;
      while (!(i_fin && d_fin)) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (post_ack) begin
            post_ack = 1'b0;
            checks++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
               errors++;
               $display("FAIL rnd_strobe_drop cyc %0d: read=%b write=%b want 0 0", cyc, mem_read, mem_write);
            end
         end else if (!busy) begin
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
               busy = 1'b1; cnt = 1; lat = $urandom_range(1, 4);
               t_addr = mem_address; t_rd = mem_read; t_wr = mem_write; t_wd = mem_writedata;
               checks++;
               if (t_addr[ADDR_W-1]) begin
                  d_starts++;
                  if (!d_pend || t_addr !== d_exp_addr || t_wr !== d_exp_wr || t_rd !== !d_exp_wr ||
                      (t_wr && t_wd !== d_exp_wdata)) begin
                     errors++;
                     $display("FAIL rnd_d_txn cyc %0d: pend=%b addr=%h rd=%b wr=%b want addr %h wr %b",
                              cyc, d_pend, t_addr, t_rd, t_wr, d_exp_addr, d_exp_wr);
                  end
               end else begin
                  i_starts++;
                  if (!i_pend || t_addr !== i_exp_addr || t_rd !== 1'b1 || t_wr !== 1'b0) begin
                     errors++;
                     $display("FAIL rnd_i_txn cyc %0d: pend=%b addr=%h rd=%b wr=%b want addr %h rd 1",
                              cyc, i_pend, t_addr, t_rd, t_wr, i_exp_addr);
                  end
               end
            end
         end else begin
            cnt++;
            checks++;
            if (mem_address !== t_addr || mem_read !== t_rd || mem_write !== t_wr) begin
               errors++;
               $display("FAIL rnd_stable cyc %0d: addr=%h rd=%b wr=%b want %h %b %b",
                        cyc, mem_address, mem_read, mem_write, t_addr, t_rd, t_wr);
            end
         end
         if (busy && cnt == lat) begin
            if (t_wr) begin
               mem_readdata  = rand_blk();
               mem_q[t_addr] = t_wd;
            end else begin
               mem_readdata = mem_q.exists(t_addr) ? mem_q[t_addr] : mem_init(t_addr);
            end
            mem_ack       = 1'b1;
            last_ack_cyc  = cyc;
            last_ack_addr = t_addr;
            busy          = 1'b0;
            post_ack      = 1'b1;
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic agent_i(input int n);
      logic [ADDR_W-1:0] addr;
      int w, snap;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         addr = 28'($urandom_range(0, 255));
         i_exp_addr = addr; i_pend = 1'b1; snap = d_starts;
         i_address = addr; i_read = 1'b1;
         #1;
         checks++;
         if (i_busywait !== 1'b1) begin
            errors++;
            $display("FAIL rnd_i_rise cyc %0d: busy=%b want 1", cyc, i_busywait);
         end
         w = 0;
         @(negedge clk);
         while (i_busywait === 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
         end
         checks++;
         if (w >= 60) begin
            errors++;
            $display("FAIL rnd_i_timeout cyc %0d: busy stuck, want done within 60 cycles", cyc);
         end else begin
            exp_i_rd = mem_init(addr);
            if (last_ack_cyc !== cyc - 1 || last_ack_addr !== addr || i_readdata !== exp_i_rd ||
                d_starts - snap > 1) begin
               errors++;
               $display("FAIL rnd_i_done cyc %0d: ack_cyc=%0d ack_addr=%h data=%h d_grants=%0d want %0d %h %h <=1",
                        cyc, last_ack_cyc, last_ack_addr, i_readdata, d_starts - snap, cyc - 1, addr, exp_i_rd);
            end
         end
         i_read = 1'b0; i_pend = 1'b0;
      end
      i_fin = 1'b1;
   endtask

   task automatic agent_d(input int n);
      logic [ADDR_W-1:0]  addr;
      logic [BLOCK_W-1:0] wd;
      int op, w, snap;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         op   = $urandom_range(0, 2);
         addr = 28'h8000000 | 28'($urandom_range(0, 15));
         wd   = rand_blk();
         d_exp_addr = addr; d_exp_wr = (op != 0); d_exp_wdata = wd; d_pend = 1'b1; snap = i_starts;
         d_address = addr; d_writedata = wd; d_read = (op != 1); d_write = (op != 0);
         #1;
         checks++;
         if (d_busywait !== 1'b1) begin
            errors++;
            $display("FAIL rnd_d_rise cyc %0d: busy=%b want 1", cyc, d_busywait);
         end
         w = 0;
         @(negedge clk);
         while (d_busywait === 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
         end
         checks++;
         if (w >= 60) begin
            errors++;
            $display("FAIL rnd_d_timeout cyc %0d: busy stuck, want done within 60 cycles", cyc);
         end else begin
            if (op == 0) exp_d_rd = d_shadow.exists(addr) ? d_shadow[addr] : mem_init(addr);
            else d_shadow[addr] = wd;
            if (last_ack_cyc !== cyc - 1 || last_ack_addr !== addr || d_readdata !== exp_d_rd ||
                i_starts - snap > 1) begin
               errors++;
               $display("FAIL rnd_d_done cyc %0d op %0d: ack_cyc=%0d ack_addr=%h data=%h i_grants=%0d want %0d %h %h <=1",
                        cyc, op, last_ack_cyc, last_ack_addr, d_readdata, i_starts - snap, cyc - 1, addr, exp_d_rd);
            end
         end
         d_read = 1'b0; d_write = 1'b0; d_pend = 1'b0;
      end
      d_fin = 1'b1;
   endtask

   task automatic test_random_traffic();
      do_reset();
      mem_q.delete();
      d_shadow.delete();
      i_pend = 1'b0; d_pend = 1'b0; i_fin = 1'b0; d_fin = 1'b0;
      i_starts = 0; d_starts = 0; last_ack_cyc = -10; last_ack_addr = '0;
      fork
         agent_i(30);
         agent_d(30);
         responder();
      join
   endtask

   initial begin
      reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ack = 1'b0;
      i_address = '0; d_address = '0; d_writedata = '0; mem_readdata = '0;
      exp_i_rd = '0; exp_d_rd = '0;
      test_reset();
      test_single_iread();
      test_simultaneous();
      test_alternation();
      test_write();
      test_reset_mid_service();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
